// File: rtl/riscv_pkg.sv
// Shared types and parameter defaults for the instruction/data memory port
// arbiter (mem_port_arbiter and its arb_pick selector).
package riscv_pkg;

    localparam int ARB_ADDR_W_DEF     = 32;
    localparam int ARB_DATA_W_DEF     = 32;
    localparam int ARB_STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Requester selection for mem_port_arbiter. Data side has fixed priority.
// With MEM_ARB_STARVE_GUARD_EN defined, a counter of consecutive data grants
// made while fetch is waiting forces one fetch grant after STARVE_MAX of them.
// Selections are only raised while the arbiter is idle, so they double as
// the grant pulses.
module arb_pick
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
)
(
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_sel_if,
    output logic o_sel_d
);

    generate
        if (STARVE_MAX < 1) begin : g_bad_starve_max
            $error("arb_pick: STARVE_MAX must be at least 1");
        end
    endgenerate

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force_if;

    assign w_force_if = i_if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign o_sel_d    = i_idle && i_d_req && !w_force_if;
    assign o_sel_if   = i_idle && i_if_req && !o_sel_d;

    // Count data grants that left fetch waiting; any fetch grant, or a data
    // grant with nobody waiting, restarts the count. The count cannot pass
    // STARVE_MAX because data is never selected at that value while fetch waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (o_sel_if) begin
            r_starve_cnt <= '0;
        end else if (o_sel_d) begin
            r_starve_cnt <= i_if_req ? r_starve_cnt + 1'b1 : '0;
        end
    end
`else
    assign o_sel_d  = i_idle && i_d_req;
    assign o_sel_if = i_idle && i_if_req && !i_d_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage (IF) and the
// load/store stage (D). One transaction at a time: grant, forward the
// latched request, wait for the single response and route it to its owner.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no transaction; grants are issued combinationally here
// ARB_REQ  | mem_req high with latched fields, waiting for mem_gnt
// ARB_RESP | request accepted, waiting for mem_rvalid to route to owner
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W_DEF,
    parameter int DATA_W     = ARB_DATA_W_DEF,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    arb_owner_t        w_owner_nxt;

    logic              w_idle;
    logic              w_sel_if;
    logic              w_sel_d;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    assign w_idle = (r_state == ARB_IDLE);

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
`ifdef MEM_ARB_STARVE_GUARD_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_d_req  (d_req),
        .o_sel_if (w_sel_if),
        .o_sel_d  (w_sel_d)
    );

    assign if_gnt = w_sel_if;
    assign d_gnt  = w_sel_d;

    // State and owner registers; reset abandons any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next state, owner tracking and response routing to the owner.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_d) begin
                    w_state_nxt = ARB_REQ;
                    w_owner_nxt = OWN_D;
                end else if (w_sel_if) begin
                    w_state_nxt = ARB_REQ;
                    w_owner_nxt = OWN_IF;
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid) begin
                    if_rvalid   = (r_owner == OWN_IF);
                    d_rvalid    = (r_owner == OWN_D);
                    w_state_nxt = ARB_IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Capture the granted request; fields then hold until the next grant,
    // which keeps them stable for the whole of ARB_REQ. Fetch leaves the
    // write-data register untouched since it is a don't-care for reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_sel_d) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_be    <= d_be;
        end else if (w_sel_if) begin
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_be    <= '1;
        end
    end

    assign mem_req   = (r_state == ARB_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    // Read data is a plain pass-through; only the rvalid pulses qualify it.
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Expected memory requests and
// responses are queued when a grant is driven and checked as the DUT
// forwards them. Starvation behaviour follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              chk_wdata;
    } mem_exp_t;

    typedef struct {
        logic              is_if;
        logic [DATA_W-1:0] data;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},   64'(mem_req),   0);
        chk({tag, "_mem_we"},    64'(mem_we),    0);
        chk({tag, "_mem_addr"},  64'(mem_addr),  0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        chk({tag, "_mem_be"},    64'(mem_be),    0);
        chk({tag, "_gnts"},      64'({if_gnt, d_gnt}), 0);
        chk({tag, "_rvalids"},   64'({if_rvalid, d_rvalid}), 0);
    endtask

    task automatic push_if(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
        mem_q.push_back('{we: 1'b0, addr: addr, wdata: '0, be: '1, chk_wdata: 1'b0});
        rsp_q.push_back('{is_if: 1'b1, data: rdata});
    endtask

    task automatic push_d(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                          input logic [DATA_W-1:0] rdata);
        mem_q.push_back('{we: we, addr: addr, wdata: wdata, be: be, chk_wdata: 1'b1});
        rsp_q.push_back('{is_if: 1'b0, data: rdata});
    endtask

    task automatic chk_mem_fields(input string tag, input mem_exp_t e);
        chk({tag, "_mem_req"},  64'(mem_req),  1);
        chk({tag, "_mem_we"},   64'(mem_we),   64'(e.we));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(e.addr));
        chk({tag, "_mem_be"},   64'(mem_be),   64'(e.be));
        if (e.chk_wdata) chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        chk({tag, "_no_gnt"},   64'({if_gnt, d_gnt}), 0);
    endtask

    // Entered one step after the edge that moved the DUT into ARB_REQ;
    // returns one step after the edge that brings it back to ARB_IDLE.
    task automatic serve(input int gnt_wait, input logic [DATA_W-1:0] rdata);
        mem_exp_t e;
        rsp_exp_t r;
        chk("mem_q_avail", 64'(mem_q.size() != 0), 1);
        if (mem_q.size() == 0) return;
        e = mem_q.pop_front();
        for (int i = 0; i < gnt_wait; i++) begin
            mem_gnt = 1'b0;
            @(negedge clk);
            chk_mem_fields("bp", e);
            next_cycle();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        chk_mem_fields("req", e);
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        chk("resp_mem_req", 64'(mem_req), 0);
        chk("resp_no_gnt", 64'({if_gnt, d_gnt}), 0);
        chk("rsp_q_avail", 64'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("if_rvalid", 64'(if_rvalid), 64'(r.is_if));
            chk("d_rvalid",  64'(d_rvalid),  64'(!r.is_if));
            chk("rdata", 64'(r.is_if ? if_rdata : d_rdata), 64'(r.data));
        end
        next_cycle();
        mem_rvalid = 1'b0;
    endtask

    task automatic req_if(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
        if_req  = 1'b1;
        if_addr = addr;
        @(negedge clk);
        chk("req_if_if_gnt", 64'(if_gnt), 1);
        chk("req_if_d_gnt",  64'(d_gnt),  0);
        push_if(addr, rdata);
        next_cycle();
        if_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                         input logic [DATA_W-1:0] rdata);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_be    = be;
        @(negedge clk);
        chk("req_d_d_gnt",  64'(d_gnt),  1);
        chk("req_d_if_gnt", 64'(if_gnt), 0);
        push_d(we, addr, wdata, be, rdata);
        next_cycle();
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected end before 200000 time units");
        $fatal(1);
    end

    initial begin
        int n_if_gnt;
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5_5A5A;

        @(negedge clk);
        chk_all_zero("reset");
        chk("reset_if_rdata_pass", 64'(if_rdata), 64'(32'hA5A5_5A5A));
        next_cycle();
        rst_n = 1'b1;

        // Reset while the response of a fetch is outstanding.
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        chk("rst_resp_if_gnt", 64'(if_gnt), 1);
        next_cycle();
        if_req  = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_resp_mem_req",  64'(mem_req),  1);
        chk("rst_resp_mem_addr", 64'(mem_addr), 64'(32'h100));
        next_cycle();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("rst_resp_in_resp", 64'(mem_req), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        next_cycle();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0BAD;
        @(negedge clk);
        chk_all_zero("rst_late_rvalid");
        next_cycle();
        mem_rvalid = 1'b0;

        // Single fetch, fastest timing; the immediate grant also shows IDLE.
        req_if(32'h100, 32'h0050_0093);
        serve(0, 32'h0050_0093);

        // Data load with partial byte enables.
        req_d(1'b0, 32'h3000, 32'h0, 4'h3, 32'hCAFE_F00D);
        serve(0, 32'hCAFE_F00D);

        // Simultaneous requests: D wins, IF follows right after d_rvalid.
        if_req  = 1'b1;
        if_addr = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'hF;
        @(negedge clk);
        chk("simul_d_gnt",  64'(d_gnt),  1);
        chk("simul_if_gnt", 64'(if_gnt), 0);
        push_d(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 32'h0);
        next_cycle();
        d_req = 1'b0;
        serve(0, 32'h0);
        @(negedge clk);
        chk("simul_if_after_d", 64'(if_gnt), 1);
        chk("simul_no_d_after", 64'(d_gnt),  0);
        push_if(32'h104, 32'h1234_5678);
        next_cycle();
        if_req = 1'b0;
        serve(0, 32'h1234_5678);

        // Memory back-pressure with a fetch waiting behind a store.
        req_d(1'b1, 32'h2004, 32'h0BAD_F00D, 4'b0110, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h108;
        serve(5, 32'h0);
        @(negedge clk);
        chk("bp_if_gnt_after", 64'(if_gnt), 1);
        push_if(32'h108, 32'h1111_2222);
        next_cycle();
        if_req = 1'b0;
        serve(2, 32'h1111_2222);

        // Spurious responses in IDLE and in REQ are not forwarded.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        @(negedge clk);
        chk("spur_idle_rvalids", 64'({if_rvalid, d_rvalid}), 0);
        chk("spur_idle_mem_req", 64'(mem_req), 0);
        next_cycle();
        mem_rvalid = 1'b0;
        req_if(32'h10C, 32'h0000_0013);
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("spur_req_rvalids", 64'({if_rvalid, d_rvalid}), 0);
        chk("spur_req_mem_req", 64'(mem_req), 1);
        next_cycle();
        mem_rvalid = 1'b0;
        serve(0, 32'h0000_0013);

        // Starvation behaviour with both requesters permanently asserting.
        rst_n = 1'b0;
        next_cycle();
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h4000;
        d_wdata = 32'h0;
        d_be    = 4'hF;
        n_if_gnt = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 10; k++) begin
            logic exp_if;
            exp_if = ((k % 5) == 4);
            @(negedge clk);
            chk("starve_if_gnt", 64'(if_gnt), 64'(exp_if));
            chk("starve_d_gnt",  64'(d_gnt),  64'(!exp_if));
            if (exp_if) push_if(32'h200, 32'(k));
            else        push_d(1'b0, 32'h4000, 32'h0, 4'hF, 32'(k));
            next_cycle();
            serve(0, 32'(k));
        end
`else
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (if_gnt) n_if_gnt++;
            chk("strict_d_gnt", 64'(d_gnt), 1);
            push_d(1'b0, 32'h4000, 32'h0, 4'hF, 32'(k));
            next_cycle();
            serve(0, 32'(k));
        end
        chk("strict_no_if_gnt", 64'(n_if_gnt), 0);
`endif
        if_req = 1'b0;
        d_req  = 1'b0;

        chk("mem_q_drained", 64'(mem_q.size()), 0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
